// File: rtl/sprite_anim_if.sv
// Handshake bundle between game logic and the sprite animation controller.
// Inputs come from the frame timer and game core; outputs feed sprite ROM muxes.
interface sprite_anim_if #(
  parameter int LW = 2,
  parameter int EW = 1
);
  logic          frame_tick;
  logic          enable;
  logic [7:0]    enemy_period;
  logic          cannon_hit;
  logic [1:0]    choose_cannon;
  logic [LW-1:0] choose_laser;
  logic [EW-1:0] enemy_frame;
  logic          enemy_step;
  logic          cannon_busy;
  logic          respawn_done;

  modport master (
    output frame_tick, enable, enemy_period, cannon_hit,
    input  choose_cannon, choose_laser, enemy_frame,
    input  enemy_step, cannon_busy, respawn_done
  );

  modport slave (
    input  frame_tick, enable, enemy_period, cannon_hit,
    output choose_cannon, choose_laser, enemy_frame,
    output enemy_step, cannon_busy, respawn_done
  );
endinterface

// File: rtl/sprite_anim_ctrl.sv
// Frame-tick driven sprite animation: enemy march, laser cycle,
// and cannon explode/respawn sequencing. All outputs registered.
module sprite_anim_ctrl #(
  parameter int ENEMY_FRAMES   = 2,
  parameter int LASER_FRAMES   = 4,
  parameter int LASER_PERIOD   = 4,
  parameter int EXPLODE_PERIOD = 8,
  parameter int EXPLODE_STEPS  = 6,
  parameter int RESPAWN_TICKS  = 60
) (
  input logic         Clk,
  input logic         Reset,
  sprite_anim_if.slave bus
);
  localparam int LW   = $clog2(LASER_FRAMES);
  localparam int EW   = $clog2(ENEMY_FRAMES);
  localparam int LPW  = $clog2(LASER_PERIOD + 1);
  localparam int TMAX = (EXPLODE_PERIOD > RESPAWN_TICKS)
                      ? EXPLODE_PERIOD : RESPAWN_TICKS;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int SW   = $clog2(EXPLODE_STEPS + 1);

  localparam logic [EW-1:0]  EMAX = EW'(ENEMY_FRAMES - 1);
  localparam logic [LW-1:0]  LMAX = LW'(LASER_FRAMES - 1);
  localparam logic [LPW-1:0] LPMX = LPW'(LASER_PERIOD - 1);
  localparam logic [TW-1:0]  TEXP = TW'(EXPLODE_PERIOD - 1);
  localparam logic [TW-1:0]  TRSP = TW'(RESPAWN_TICKS - 1);
  localparam logic [SW-1:0]  SLST = SW'(EXPLODE_STEPS - 1);

  typedef enum logic [1:0] {
    S_NORMAL,
    S_EXPLODE,
    S_RESPAWN
  } state_t;

  logic           w_tick;
  logic [7:0]     w_eper;
  logic           w_ewrap;
  logic [7:0]     r_ecnt;
  logic [EW-1:0]  r_eframe;
  logic           r_estep;
  logic [LPW-1:0] r_lcnt;
  logic [LW-1:0]  r_laser;

  state_t         r_state, w_state_nxt;
  logic [TW-1:0]  r_tcnt, w_tcnt_nxt;
  logic [SW-1:0]  r_step, w_step_nxt;
  logic [1:0]     r_cannon, w_cannon_nxt;
  logic           r_busy, w_busy_nxt;
  logic           r_done, w_done_nxt;

  assign w_tick  = bus.frame_tick & bus.enable;
  assign w_eper  = (bus.enemy_period == 8'd0) ? 8'd1 : bus.enemy_period;
  // >= rather than == so a lowered period steps at once instead of wrapping
  assign w_ewrap = (r_ecnt >= (w_eper - 8'd1));

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ecnt   <= '0;
      r_eframe <= '0;
      r_estep  <= 1'b0;
      r_lcnt   <= '0;
      r_laser  <= '0;
    end else begin
      r_estep <= 1'b0;
      if (w_tick) begin
        if (w_ewrap) begin
          r_ecnt   <= '0;
          r_eframe <= (r_eframe == EMAX) ? '0 : r_eframe + 1'b1;
          r_estep  <= 1'b1;
        end else begin
          r_ecnt <= r_ecnt + 8'd1;
        end
        if (r_lcnt == LPMX) begin
          r_lcnt  <= '0;
          r_laser <= (r_laser == LMAX) ? '0 : r_laser + 1'b1;
        end else begin
          r_lcnt <= r_lcnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state  <= S_NORMAL;
      r_tcnt   <= '0;
      r_step   <= '0;
      r_cannon <= 2'd0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_tcnt   <= w_tcnt_nxt;
      r_step   <= w_step_nxt;
      r_cannon <= w_cannon_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_step_nxt  = r_step;
    w_done_nxt  = 1'b0;
    unique case (r_state)
      S_NORMAL: begin
        if (bus.cannon_hit) begin
          w_state_nxt = S_EXPLODE;
          w_tcnt_nxt  = '0;
          w_step_nxt  = '0;
        end
      end
      S_EXPLODE: begin
        if (w_tick) begin
          if (r_tcnt == TEXP) begin
            w_tcnt_nxt = '0;
            if (r_step == SLST) begin
              w_state_nxt = S_RESPAWN;
              w_step_nxt  = '0;
            end else begin
              w_step_nxt = r_step + 1'b1;
            end
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      S_RESPAWN: begin
        if (w_tick) begin
          if (r_tcnt == TRSP) begin
            w_state_nxt = S_NORMAL;
            w_tcnt_nxt  = '0;
            w_done_nxt  = 1'b1;
          end else begin
            w_tcnt_nxt = r_tcnt + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_NORMAL;
        w_tcnt_nxt  = '0;
        w_step_nxt  = '0;
      end
    endcase
  end

  always_comb begin
    w_cannon_nxt = 2'd0;
    w_busy_nxt   = (w_state_nxt != S_NORMAL);
    unique case (w_state_nxt)
      S_EXPLODE: w_cannon_nxt = w_step_nxt[0] ? 2'd2 : 2'd1;
      S_RESPAWN: w_cannon_nxt = 2'd3;
      default:   w_cannon_nxt = 2'd0;
    endcase
  end

  assign bus.choose_cannon = r_cannon;
  assign bus.choose_laser  = r_laser;
  assign bus.enemy_frame   = r_eframe;
  assign bus.enemy_step    = r_estep;
  assign bus.cannon_busy   = r_busy;
  assign bus.respawn_done  = r_done;
endmodule

// File: doc/sprite_anim_ctrl.md
Name: sprite_anim_ctrl

Overview:
- Parametrised successor to the static sprite-select controller.
- Drives time-varying sprite selects from the VGA frame tick:
  - enemy animation frame, with a run-time programmable march period
  - laser animation frame
  - cannon explode/respawn sequence triggered by a hit event
- Outputs feed the sprite ROM address muxes, which then feed the palette lookup.

Parameters:
ENEMY_FRAMES, 2, number of enemy animation frames (>=2)
LASER_FRAMES, 4, number of laser animation frames (>=2)
LASER_PERIOD, 4, frame ticks per laser frame step (>=1)
EXPLODE_PERIOD, 8, frame ticks per cannon explosion frame step (>=1)
EXPLODE_STEPS, 6, explosion frame steps before respawn wait (>=1)
RESPAWN_TICKS, 60, frame ticks cannon stays hidden after explosion (>=1)

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous, active-high reset
frame_tick  input  1  one-cycle pulse per VGA frame
enable  input  1  1 = game running; 0 = pause, all tick counters frozen
enemy_period  input  8  frame ticks per enemy frame step; 0 treated as 1
cannon_hit  input  1  one-cycle pulse, cannon destroyed
choose_cannon  output  2  0 normal, 1 explode A, 2 explode B, 3 hidden
choose_laser  output  $clog2(LASER_FRAMES)  laser frame index
enemy_frame  output  $clog2(ENEMY_FRAMES)  enemy frame index
enemy_step  output  1  one-cycle pulse when enemy_frame advances (march strobe)
cannon_busy  output  1  1 whenever cannon FSM not in NORMAL
respawn_done  output  1  one-cycle pulse on RESPAWN -> NORMAL

Behaviour:
- Clock, reset and outputs:
  - Clk is the only clock; Reset is synchronous, active-high.
  - All outputs are registered.
  - Reset values: all outputs 0; all counters 0; FSM = NORMAL.
- Advance condition: a "tick" is frame_tick & enable. Only ticks advance counters.
- Enemy counter ecnt:
  - On a tick, if ecnt >= max(enemy_period,1)-1: ecnt <= 0, enemy_frame <= (enemy_frame+1) mod ENEMY_FRAMES, enemy_step <= 1 for that one cycle.
  - Otherwise ecnt <= ecnt+1.
  - enemy_period is sampled every tick. Lowering it below the current ecnt forces a step on the next tick (no long wrap).
- Laser counter: same scheme with fixed LASER_PERIOD; choose_laser wraps LASER_FRAMES-1 -> 0.
- Latency: an output update appears on the cycle after the qualifying tick.
- Cannon FSM: NORMAL, EXPLODE, RESPAWN.
  - NORMAL:
    - choose_cannon=0.
    - On cannon_hit (independent of enable): go to EXPLODE, step=0, tcnt=0, choose_cannon=1.
  - EXPLODE:
    - Each tick: tcnt++.
    - When tcnt reaches EXPLODE_PERIOD-1: tcnt=0, step++, choose_cannon toggles 1<->2.
    - When step would reach EXPLODE_STEPS: go to RESPAWN, tcnt=0, choose_cannon=3.
  - RESPAWN:
    - Each tick: tcnt++.
    - At RESPAWN_TICKS-1: go to NORMAL, choose_cannon=0, respawn_done pulse for one cycle.
  - cannon_busy = (state != NORMAL), registered alongside the state.
- Simultaneous events:
  - cannon_hit while in EXPLODE or RESPAWN is ignored.
  - cannon_hit and a tick in the same cycle while in NORMAL: the hit is taken; that tick does not count toward the explosion.
- Pause: with enable=0, cannon_hit is still accepted, but no explosion or respawn progress is made until enable returns.
- Reset mid-sequence: immediately NORMAL, choose_cannon=0, no respawn_done pulse.
- Laser and enemy animation keep running during cannon explode/respawn.
- Counter widths: ecnt is 8 bits; tcnt is wide enough for max(EXPLODE_PERIOD, RESPAWN_TICKS)-1; no overflow is possible.

Test Plan:
- Reset, then 10 ticks with enemy_period=3 -> enemy_frame toggles after ticks 3, 6, 9 (0->1->0->1); enemy_step pulses exactly 3 times, each one cycle wide.
- enemy_period=0, 4 ticks -> enemy_frame advances on every tick; enemy_step high after each of the 4 ticks.
- LASER_PERIOD=4, LASER_FRAMES=4, 17 ticks -> choose_laser sequence 0,1,2,3,0 with changes after ticks 4, 8, 12, 16.
- cannon_hit in NORMAL (defaults) -> choose_cannon=1 next cycle, cannon_busy=1; 1/2 alternates every 8 ticks for 6 steps (48 ticks); then 3 for 60 ticks; then 0 with a single respawn_done pulse. A second cannon_hit at tick 20 has no effect.
- enable=0 during EXPLODE with 50 frame_ticks -> choose_cannon and all animation outputs hold; resume enable -> sequence continues from the held count.
- Reset asserted at tick 30 of EXPLODE -> next cycle choose_cannon=0, cannon_busy=0, respawn_done stays 0; cannon_hit plus frame_tick in the same cycle -> EXPLODE entered with tcnt=0.
